tdm_demux_rx: RTL and testbench

//  Receive end of the 4-slot time-division link. The transmit end is a slot counter driving a 4:1 mux.

---
 rtl/tdm_pkg.sv | 20 ++
 rtl/tdm_slot_counter.sv | 48 ++++
 rtl/tdm_demux_rx.sv | 130 +++++++++++++
 tb/tb_tdm_demux_rx.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared definitions for both ends of the 4-slot TDM link: the FSM state type,
// default geometry, and the helper that locates a slot's field inside a frame word.
package tdm_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        RECV = 1'b1
    } state_e;

    localparam int NUM_SLOTS_DEF = 4;
    localparam int DATA_W_DEF    = 1;
    localparam int ERR_W_DEF     = 8;
    localparam int SLOT_W        = $clog2(NUM_SLOTS_DEF);

    // Bit offset of slot 'slot_idx' in a frame word of 'data_w'-bit slots.
    function automatic int slot_lsb(input int slot_idx, input int data_w);
        return slot_idx * data_w;
    endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot index counter shared by the transmit and receive ends of the TDM link.
// Clear wins over load-to-1, which wins over a plain increment; wrap_o flags the last slot.
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int NUM_SLOTS = NUM_SLOTS_DEF,
    parameter int SLOT_BITS = $clog2(NUM_SLOTS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en_i,
    input  logic                 clr_i,
    input  logic                 load1_i,
    output logic [SLOT_BITS-1:0] count_o,
    output logic                 wrap_o
);

    localparam logic [SLOT_BITS-1:0] LAST = SLOT_BITS'(NUM_SLOTS - 1);
    localparam logic [SLOT_BITS-1:0] ONE  = SLOT_BITS'(1);

    logic [SLOT_BITS-1:0] count_q;
    logic [SLOT_BITS-1:0] count_d;

    // Next count: clear, load the slot after slot 0, or advance with wrap at the last slot.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (load1_i) begin
            count_d = ONE;
        end else if (en_i) begin
            count_d = (count_q == LAST) ? '0 : count_q + ONE;
        end
    end

    // Count register, cleared by the link's active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign wrap_o  = (count_q == LAST);

endmodule

// File: rtl/tdm_demux_rx.sv
// Receive end of the TDM link: hunts for frame_start, collects one slot per enabled
// clock into a shadow bank, publishes whole frames, and counts alignment violations.
module tdm_demux_rx
    import tdm_pkg::*;
#(
    parameter int NUM_SLOTS = NUM_SLOTS_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ERR_W     = ERR_W_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [DATA_W-1:0]           serial_in,
    input  logic                        frame_start,
    output logic [NUM_SLOTS*DATA_W-1:0] data_out,
    output logic                        frame_valid,
    output logic [$clog2(NUM_SLOTS)-1:0] slot,
    output logic                        locked,
    output logic                        sync_err,
    output logic [ERR_W-1:0]            err_count
);

    localparam int SLOT_BITS = $clog2(NUM_SLOTS);
    localparam int SHADOW_W  = (NUM_SLOTS - 1) * DATA_W;

    state_e                       state_q, state_d;
    logic [SHADOW_W-1:0]          shadow_q, shadow_d;
    logic [NUM_SLOTS*DATA_W-1:0]  data_q, data_d;
    logic                         fv_q, fv_d;
    logic                         se_q, se_d;
    logic [ERR_W-1:0]             err_q, err_d;

    logic                         cnt_clr, cnt_load1, cnt_inc;
    logic [SLOT_BITS-1:0]         slot_q;
    logic                         slot_last;

    tdm_slot_counter #(
        .NUM_SLOTS (NUM_SLOTS),
        .SLOT_BITS (SLOT_BITS)
    ) u_slot_counter (
        .clk     (clk),
        .reset   (reset),
        .en_i    (cnt_inc),
        .clr_i   (cnt_clr),
        .load1_i (cnt_load1),
        .count_o (slot_q),
        .wrap_o  (slot_last)
    );

    // Alignment FSM and slot capture; nothing moves unless enable is high.
    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        data_d    = data_q;
        fv_d      = 1'b0;
        se_d      = 1'b0;
        err_d     = err_q;
        cnt_clr   = 1'b0;
        cnt_load1 = 1'b0;
        cnt_inc   = 1'b0;
        if (enable) begin
            unique case (state_q)
                HUNT: begin
                    if (frame_start) begin
                        shadow_d[DATA_W-1:0] = serial_in;
                        cnt_load1            = 1'b1;
                        state_d              = RECV;
                    end
                end
                RECV: begin
                    if (frame_start) begin
                        // A frame_start anywhere but slot 0 abandons the partial frame.
                        se_d                 = (slot_q != '0);
                        shadow_d[DATA_W-1:0] = serial_in;
                        cnt_load1            = 1'b1;
                    end else if (slot_q == '0) begin
                        se_d    = 1'b1;
                        cnt_clr = 1'b1;
                        state_d = HUNT;
                    end else if (slot_last) begin
                        data_d  = {serial_in, shadow_q};
                        fv_d    = 1'b1;
                        cnt_inc = 1'b1;
                    end else begin
                        shadow_d[slot_lsb(int'(slot_q), DATA_W) +: DATA_W] = serial_in;
                        cnt_inc = 1'b1;
                    end
                end
                default: state_d = HUNT;
            endcase
            if (se_d && (err_q != '1)) begin
                err_d = err_q + ERR_W'(1);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // Shadow bank, output word, pulse flags and saturating error counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_q <= '0;
            data_q   <= '0;
            fv_q     <= 1'b0;
            se_q     <= 1'b0;
            err_q    <= '0;
        end else begin
            shadow_q <= shadow_d;
            data_q   <= data_d;
            fv_q     <= fv_d;
            se_q     <= se_d;
            err_q    <= err_d;
        end
    end

    assign data_out    = data_q;
    assign frame_valid = fv_q & enable;
    assign sync_err    = se_q & enable;
    assign slot        = slot_q;
    assign locked      = (state_q == RECV);
    assign err_count   = err_q;

endmodule

// File: tb/tb_tdm_demux_rx.sv
// Directed bench for tdm_demux_rx with NUM_SLOTS=4, DATA_W=1, ERR_W=8.
module tb_tdm_demux_rx;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [0:0] serial_in;
    logic       frame_start;
    logic [3:0] data_out;
    logic       frame_valid;
    logic [1:0] slot;
    logic       locked;
    logic       sync_err;
    logic [7:0] err_count;

    int assertCount = 0;
    int failCount   = 0;

    typedef struct {
        logic       en;
        logic       fs;
        logic       sin;
        logic [3:0] expData;
        logic       expFv;
        logic [1:0] expSlot;
        logic       expLocked;
        logic       expSe;
        logic [7:0] expErr;
    } vec_t;

    vec_t vecs[29];

    tdm_demux_rx #(
        .NUM_SLOTS (4),
        .DATA_W    (1),
        .ERR_W     (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .serial_in   (serial_in),
        .frame_start (frame_start),
        .data_out    (data_out),
        .frame_valid (frame_valid),
        .slot        (slot),
        .locked      (locked),
        .sync_err    (sync_err),
        .err_count   (err_count)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs and move to 1 ns after the sampling edge.
    task automatic applyStimulus(input logic en, input logic fs, input logic sin);
        enable      = en;
        frame_start = fs;
        serial_in   = sin;
        @(posedge clk);
        #1;
    endtask

    task automatic checkAll(input string tag, input logic [3:0] d, input logic fv, input logic [1:0] s,
                            input logic lk, input logic se, input logic [7:0] ec);
        checkOutput({tag, ".data"},   32'(data_out),    32'(d));
        checkOutput({tag, ".fv"},     32'(frame_valid), 32'(fv));
        checkOutput({tag, ".slot"},   32'(slot),        32'(s));
        checkOutput({tag, ".locked"}, 32'(locked),      32'(lk));
        checkOutput({tag, ".se"},     32'(sync_err),    32'(se));
        checkOutput({tag, ".err"},    32'(err_count),   32'(ec));
    endtask

    // Main sequence: reset, table of vectors, then the saturation and async-reset corners.
    initial begin
        int errExp;

        // Clean frames 1,0,1,1 -> 1101 and 0,1,1,0 -> 0110.
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b1, 1'b0, 8'd0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b1, 1'b0, 8'd0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b1, 1'b0, 8'd0};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 4'b1101, 1'b1, 2'd0, 1'b1, 1'b0, 8'd0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 4'b1101, 1'b0, 2'd1, 1'b1, 1'b0, 8'd0};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 4'b1101, 1'b0, 2'd2, 1'b1, 1'b0, 8'd0};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 4'b1101, 1'b0, 2'd3, 1'b1, 1'b0, 8'd0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 4'b0110, 1'b1, 2'd0, 1'b1, 1'b0, 8'd0};
        // Early frame_start at slot 2; its sample becomes slot 0 of the new frame.
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 4'b0110, 1'b0, 2'd1, 1'b1, 1'b0, 8'd0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 4'b0110, 1'b0, 2'd2, 1'b1, 1'b0, 8'd0};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 4'b0110, 1'b0, 2'd1, 1'b1, 1'b1, 8'd1};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 4'b0110, 1'b0, 2'd2, 1'b1, 1'b0, 8'd1};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 4'b0110, 1'b0, 2'd3, 1'b1, 1'b0, 8'd1};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 4'b0101, 1'b1, 2'd0, 1'b1, 1'b0, 8'd1};
        // Missing frame_start at slot 0 drops lock; a new frame_start relocks.
        vecs[14] = '{1'b1, 1'b0, 1'b1, 4'b0101, 1'b0, 2'd0, 1'b0, 1'b1, 8'd2};
        vecs[15] = '{1'b1, 1'b0, 1'b1, 4'b0101, 1'b0, 2'd0, 1'b0, 1'b0, 8'd2};
        vecs[16] = '{1'b1, 1'b1, 1'b0, 4'b0101, 1'b0, 2'd1, 1'b1, 1'b0, 8'd2};
        vecs[17] = '{1'b1, 1'b0, 1'b0, 4'b0101, 1'b0, 2'd2, 1'b1, 1'b0, 8'd2};
        vecs[18] = '{1'b1, 1'b0, 1'b1, 4'b0101, 1'b0, 2'd3, 1'b1, 1'b0, 8'd2};
        vecs[19] = '{1'b1, 1'b0, 1'b1, 4'b1100, 1'b1, 2'd0, 1'b1, 1'b0, 8'd2};
        // Enable gap of 5 clocks between slots 1 and 2 with toggling inputs.
        vecs[20] = '{1'b1, 1'b1, 1'b1, 4'b1100, 1'b0, 2'd1, 1'b1, 1'b0, 8'd2};
        vecs[21] = '{1'b1, 1'b0, 1'b0, 4'b1100, 1'b0, 2'd2, 1'b1, 1'b0, 8'd2};
        vecs[22] = '{1'b0, 1'b0, 1'b1, 4'b1100, 1'b0, 2'd2, 1'b1, 1'b0, 8'd2};
        vecs[23] = '{1'b0, 1'b0, 1'b0, 4'b1100, 1'b0, 2'd2, 1'b1, 1'b0, 8'd2};
        vecs[24] = '{1'b0, 1'b1, 1'b1, 4'b1100, 1'b0, 2'd2, 1'b1, 1'b0, 8'd2};
        vecs[25] = '{1'b0, 1'b0, 1'b0, 4'b1100, 1'b0, 2'd2, 1'b1, 1'b0, 8'd2};
        vecs[26] = '{1'b0, 1'b0, 1'b1, 4'b1100, 1'b0, 2'd2, 1'b1, 1'b0, 8'd2};
        vecs[27] = '{1'b1, 1'b0, 1'b1, 4'b1100, 1'b0, 2'd3, 1'b1, 1'b0, 8'd2};
        vecs[28] = '{1'b1, 1'b0, 1'b0, 4'b0101, 1'b1, 2'd0, 1'b1, 1'b0, 8'd2};

        reset       = 1'b0;
        enable      = 1'b0;
        frame_start = 1'b0;
        serial_in   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkAll("inReset", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 8'd0);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkAll("afterReset", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 8'd0);

        for (int i = 0; i < 29; i++) begin
            applyStimulus(vecs[i].en, vecs[i].fs, vecs[i].sin);
            checkAll($sformatf("vec%0d", i), vecs[i].expData, vecs[i].expFv, vecs[i].expSlot,
                     vecs[i].expLocked, vecs[i].expSe, vecs[i].expErr);
        end

        // Repeated frame_start at slot 1 forces one sync error per clock.
        errExp = 2;
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkAll("satStart", 4'b0101, 1'b0, 2'd1, 1'b1, 1'b0, 8'(errExp));
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0);
            errExp = (errExp < 255) ? errExp + 1 : 255;
            checkOutput($sformatf("sat%0d.err", i), 32'(err_count), 32'(errExp));
            checkOutput($sformatf("sat%0d.se", i), 32'(sync_err), 32'd1);
        end
        checkOutput("satFinal.err", 32'(err_count), 32'hFF);
        checkOutput("satFinal.slot", 32'(slot), 32'd1);

        // Async reset mid-frame must clear outputs before the next clock edge.
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkAll("preReset", 4'b0101, 1'b0, 2'd2, 1'b1, 1'b0, 8'hFF);
        #2;
        reset = 1'b0;
        #1;
        checkAll("asyncReset", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 8'd0);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkAll("postResetHunt", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 8'd0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkAll("postResetFrame", 4'b0100, 1'b1, 2'd0, 1'b1, 1'b0, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
